tone_generator: RTL

- Sequential tone player: converts a half-period count (format produced by the key-number-to-frequency mapper) plus a note length into a square wave on `tone` for the piezo/speaker pin.
- Start/busy/done handshake lets the game sequencer queue notes back-to-back.
- Sits between the frequency mapper / melody sequencer and the audio output pin.

---
 rtl/tone_generator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tone_generator.sv
// tone_generator: plays one note as a square wave on `tone`.
// Inputs are a half-period count in clock cycles and a note length in full
// output periods. A start/busy/done handshake lets a sequencer queue notes
// back to back. A frequency of 0 plays a silent rest of the same length.
// Optional build macro TONE_ABORT_EN adds a `stop` input that cuts a note short.
module tone_generator #(
  parameter int CNT_W     = 15,
  parameter int LEN_W     = 10,
  parameter int REST_HALF = 6250,
  parameter int MIN_HALF  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frequency,
  input  logic [LEN_W-1:0] length,
`ifdef TONE_ABORT_EN
  input  logic             stop,
`endif
  output logic             tone,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] halfCnt_q, halfCnt_d;
  logic [CNT_W-1:0] halfLen_q, halfLen_d;
  logic [LEN_W-1:0] periodCnt_q, periodCnt_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic             rest_q, rest_d;
  logic             phase_q, phase_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] effHalf;

  // Effective half-period: rests use a fixed timebase, tiny values are clamped up.
  always_comb begin
    effHalf = frequency;
    if (frequency == '0) begin
      effHalf = CNT_W'(REST_HALF);
    end else if (frequency < CNT_W'(MIN_HALF)) begin
      effHalf = CNT_W'(MIN_HALF);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      halfCnt_q   <= '0;
      halfLen_q   <= '0;
      periodCnt_q <= '0;
      length_q    <= '0;
      rest_q      <= 1'b0;
      phase_q     <= 1'b0;
      tone_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      halfCnt_q   <= halfCnt_d;
      halfLen_q   <= halfLen_d;
      periodCnt_q <= periodCnt_d;
      length_q    <= length_d;
      rest_q      <= rest_d;
      phase_q     <= phase_d;
      tone_q      <= tone_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: latch the note on start, then walk half-periods and periods.
  always_comb begin
    state_d     = state_q;
    halfCnt_d   = halfCnt_q;
    halfLen_d   = halfLen_q;
    periodCnt_d = periodCnt_q;
    length_d    = length_q;
    rest_d      = rest_q;
    phase_d     = phase_q;
    tone_d      = tone_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        tone_d = 1'b0;
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = PLAY;
            halfLen_d   = effHalf;
            length_d    = length;
            rest_d      = (frequency == '0);
            halfCnt_d   = '0;
            periodCnt_d = '0;
            phase_d     = 1'b1;
            tone_d      = (frequency != '0);
          end
        end
      end

      PLAY: begin
        if (halfCnt_q == halfLen_q - CNT_W'(1)) begin
          halfCnt_d = '0;
          if (phase_q) begin
            phase_d     = 1'b0;
            tone_d      = 1'b0;
            periodCnt_d = periodCnt_q + LEN_W'(1);
          end else if (periodCnt_q == length_q) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            tone_d      = 1'b0;
            periodCnt_d = '0;
          end else begin
            phase_d = 1'b1;
            tone_d  = ~rest_q;
          end
        end else begin
          halfCnt_d = halfCnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tone_d  = 1'b0;
      end
    endcase

`ifdef TONE_ABORT_EN
    if ((state_q == PLAY) && stop) begin
      state_d     = IDLE;
      tone_d      = 1'b0;
      done_d      = 1'b1;
      halfCnt_d   = '0;
      periodCnt_d = '0;
      phase_d     = 1'b0;
    end
`endif
  end

  assign tone = tone_q;
  assign busy = (state_q == PLAY);
  assign done = done_q;

endmodule
